// File: rtl/tokens_pkg.sv
// Shared types and helpers for the token packer.
// Lane indices are sized for the largest supported ratio.
package tokens_pkg;

    localparam int MAX_RATIO = 16;
    localparam int LANE_W = $clog2(MAX_RATIO);

    typedef logic [LANE_W-1:0] lane_t;

    function automatic int cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/tokens_pack.sv
// Packs up to RATIO narrow tokens into one wide word.
// A packet end (src_lst) closes the word early.
module tokens_pack
    import tokens_pkg::*;
#(
    parameter int DW = 32,
    parameter int RATIO = 4,
    parameter int CW = cnt_w(RATIO)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_vld,
    output logic                  src_rdy,
    input  logic [DW-1:0]         src_dat,
    input  logic                  src_lst,
    output logic                  dst_vld,
    input  logic                  dst_rdy,
    output logic [DW*RATIO-1:0]   dst_dat,
    output logic [CW-1:0]         dst_cnt,
    output logic                  dst_lst
);

    localparam lane_t LAST = lane_t'(RATIO - 1);

    logic [RATIO-1:0][DW-1:0] lanes_q;
    lane_t                    lane;
    logic                     src_xfer;
    logic                     pop;
    logic                     push_fill;

    assign src_rdy   = !dst_vld || dst_rdy;
    assign src_xfer  = src_vld && src_rdy;
    assign pop       = dst_vld && dst_rdy;
    assign push_fill = !dst_vld && src_xfer;
    assign dst_dat   = lanes_q;

    // Unwritten lanes stay zero because the buffer is cleared on every pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q <= '0;
            lane    <= '0;
            dst_vld <= 1'b0;
            dst_cnt <= '0;
            dst_lst <= 1'b0;
        end else begin
            unique case (1'b1)
                pop: begin
                    lanes_q <= '0;
                    lane    <= '0;
                    dst_vld <= 1'b0;
                    dst_cnt <= '0;
                    dst_lst <= 1'b0;
                    if (src_xfer) begin
                        lanes_q[0] <= src_dat;
                        if (RATIO == 1 || src_lst) begin
                            dst_vld <= 1'b1;
                            dst_cnt <= CW'(1);
                            dst_lst <= src_lst;
                        end else begin
                            lane <= lane_t'(1);
                        end
                    end
                end
                push_fill: begin
                    for (int i = 0; i < RATIO; i++) begin
                        if (lane == lane_t'(i)) begin
                            lanes_q[i] <= src_dat;
                        end
                    end
                    if (lane == LAST || src_lst) begin
                        dst_vld <= 1'b1;
                        dst_cnt <= CW'(lane) + CW'(1);
                        dst_lst <= src_lst;
                        lane    <= '0;
                    end else begin
                        lane <= lane + lane_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
